// File: rtl/bist_ctrl_if.sv
// Control/status bundle between the March C- sequencer (master) and the BIST datapath (slave).
interface bist_ctrl_if #(
    parameter int Adr_size = 4,
    parameter int Err_w    = 8
);
    logic                start;
    logic                c_out;
    logic [Adr_size-1:0] adress;
    logic                error;
    logic                enable;
    logic                rst_adr;
    logic                pr_res_adr;
    logic                up_down;
    logic                read_en;
    logic                wr_en;
    logic                data_bit;
    logic                busy;
    logic                done;
    logic                fail;
    logic [2:0]          fail_elem;
    logic [Adr_size-1:0] fail_adr;
    logic [Err_w-1:0]    err_cnt;

    modport master (
        input  start, c_out, adress, error,
        output enable, rst_adr, pr_res_adr, up_down, read_en, wr_en, data_bit,
               busy, done, fail, fail_elem, fail_adr, err_cnt
    );

    modport slave (
        output start, c_out, adress, error,
        input  enable, rst_adr, pr_res_adr, up_down, read_en, wr_en, data_bit,
               busy, done, fail, fail_elem, fail_adr, err_cnt
    );
endinterface

// File: rtl/bist_ctrl.sv
// March C- BIST sequencer: one memory op per cycle, 6 INIT + 10N cycles per fault-free run.
// BIST_STOP_ON_FAIL_EN: end the run on the edge after the first mismatching read.
module bist_ctrl #(
    parameter int Adr_size = 4,
    parameter int Err_w    = 8
) (
    input  logic          clk,
    input  logic          rst,
    bist_ctrl_if.master   bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] E_FIRST = 3'd0;
    localparam logic [2:0] E_LAST  = 3'd5;

`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit StopOnFail = 1'b1;
`else
    localparam bit StopOnFail = 1'b0;
`endif

    logic [2:0]          state_q, state_d;
    logic [2:0]          elem_q, elem_d;
    logic                fail_q, fail_d;
    logic [2:0]          fail_elem_q, fail_elem_d;
    logic [Adr_size-1:0] fail_adr_q, fail_adr_d;
    logic [Err_w-1:0]    err_cnt_q, err_cnt_d;

    logic elem_up;
    logic rd_val;
    logic wr_val;
    logic busy;
    logic last_op;

    // M3/M4 walk downwards; M2/M4 read ones, M1/M3 write ones.
    assign elem_up = (elem_q != 3'd3) && (elem_q != 3'd4);
    assign rd_val  = (elem_q == 3'd2) || (elem_q == 3'd4);
    assign wr_val  = (elem_q == 3'd1) || (elem_q == 3'd3);
    assign busy    = (state_q == S_INIT) || (state_q == S_RD) || (state_q == S_WR);
    assign last_op = (state_q == S_WR) || ((state_q == S_RD) && (elem_q == E_LAST));

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        fail_d      = fail_q;
        fail_elem_d = fail_elem_q;
        fail_adr_d  = fail_adr_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d     = S_INIT;
                    elem_d      = E_FIRST;
                    fail_d      = 1'b0;
                    fail_elem_d = '0;
                    fail_adr_d  = '0;
                    err_cnt_d   = '0;
                end
            end
            S_INIT: state_d = (elem_q == E_FIRST) ? S_WR : S_RD;
            S_RD: begin
                if (bus.error) begin
                    fail_d = 1'b1;
                    if (!(&err_cnt_q)) begin
                        err_cnt_d = err_cnt_q + Err_w'(1);
                    end
                    if (!fail_q) begin
                        fail_elem_d = elem_q;
                        fail_adr_d  = bus.adress;
                    end
                end
                if (bus.error && StopOnFail) begin
                    state_d = S_DONE;
                end else if (elem_q == E_LAST) begin
                    state_d = bus.c_out ? S_DONE : S_RD;
                end else begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (bus.c_out) begin
                    state_d = S_INIT;
                    elem_d  = elem_q + 3'd1;
                end else begin
                    state_d = (elem_q == E_FIRST) ? S_WR : S_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            elem_q      <= '0;
            fail_q      <= 1'b0;
            fail_elem_q <= '0;
            fail_adr_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            fail_q      <= fail_d;
            fail_elem_q <= fail_elem_d;
            fail_adr_q  <= fail_adr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // enable depends on c_out in the same cycle so the final address is never stepped past.
    assign bus.enable     = last_op && !bus.c_out;
    assign bus.rst_adr    = (state_q == S_INIT) && elem_up;
    assign bus.pr_res_adr = (state_q == S_INIT) && !elem_up;
    assign bus.up_down    = busy && elem_up;
    assign bus.read_en    = (state_q == S_RD);
    assign bus.wr_en      = (state_q == S_WR);
    assign bus.data_bit   = ((state_q == S_RD) && rd_val) || ((state_q == S_WR) && wr_val);
    assign bus.busy       = busy;
    assign bus.done       = (state_q == S_DONE);
    assign bus.fail       = fail_q;
    assign bus.fail_elem  = fail_elem_q;
    assign bus.fail_adr   = fail_adr_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_bist_ctrl.sv
// Bench: address generator + 1-bit memory with an injectable stuck-at cell, checked against a March C- trace model.
module tb_bist_ctrl;
    localparam int AW = 4;
    localparam int EW = 8;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bist_ctrl_if #(.Adr_size(AW), .Err_w(EW)) bif ();
    bist_ctrl #(.Adr_size(AW), .Err_w(EW)) dut (.clk(clk), .rst(rst), .bus(bif));

    typedef struct packed {
        logic          busy, done, rst_adr, pr, up_down, rd, wr, en, dbit;
        logic [AW-1:0] adr;
    } ctl_t;

    int n_vec = 0;
    int n_err = 0;

    // datapath environment
    int            depth;
    bit            flt_en, flt_val, noise_en, noise_q;
    int            flt_adr;
    logic [AW-1:0] dp_adr;
    bit            dp_mem [N];
    bit            rd_bit;

    always @(posedge clk) begin
        noise_q <= 1'($urandom);
        if (bif.rst_adr)         dp_adr <= '0;
        else if (bif.pr_res_adr) dp_adr <= AW'(depth - 1);
        else if (bif.enable)     dp_adr <= bif.up_down ? dp_adr + 1'b1 : dp_adr - 1'b1;
        if (bif.wr_en) dp_mem[dp_adr] <= bif.data_bit;
    end

    always_comb begin
        rd_bit     = (flt_en && int'(dp_adr) == flt_adr) ? flt_val : dp_mem[dp_adr];
        bif.c_out  = bif.up_down ? (int'(dp_adr) == depth - 1) : (dp_adr == '0);
        bif.adress = dp_adr;
        bif.error  = bif.read_en ? (rd_bit != bif.data_bit) : (noise_en & noise_q);
    end

    // March C- table: M0 up(w0) M1 up(r0,w1) M2 up(r1,w0) M3 dn(r0,w1) M4 dn(r1,w0) M5 up(r0)
    int nops   [6] = '{1, 2, 2, 2, 2, 1};
    bit dir_up [6] = '{1, 1, 1, 0, 0, 1};
    bit rdv    [6] = '{0, 0, 1, 0, 1, 0};
    bit wrv    [6] = '{0, 1, 0, 1, 0, 0};

    ctl_t exp_q[$];
    int   exp_len, exp_err, exp_felem, exp_fadr;
    bit   exp_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_model();
        bit   mem [N];
        bit   stop;
        ctl_t c;
        stop = 1'b0;
        exp_q.delete();
        exp_err = 0; exp_fail = 1'b0; exp_felem = 0; exp_fadr = 0;
        foreach (mem[i]) mem[i] = 1'b0;
        for (int e = 0; e < 6 && !stop; e++) begin
            c = '0; c.busy = 1'b1; c.rst_adr = dir_up[e]; c.pr = !dir_up[e]; c.up_down = dir_up[e];
            exp_q.push_back(c);
            for (int k = 0; k < depth && !stop; k++) begin
                int a;
                a = dir_up[e] ? k : depth - 1 - k;
                for (int o = 0; o < nops[e] && !stop; o++) begin
                    bit rd;
                    bit got;
                    rd = (e != 0) && (o == 0);
                    c = '0; c.busy = 1'b1; c.up_down = dir_up[e]; c.rd = rd; c.wr = !rd;
                    c.dbit = rd ? rdv[e] : wrv[e];
                    c.en = (o == nops[e] - 1) && (k != depth - 1);
                    c.adr = AW'(a);
                    exp_q.push_back(c);
                    if (rd) begin
                        got = (flt_en && a == flt_adr) ? flt_val : mem[a];
                        if (got != rdv[e]) begin
                            if (exp_err < (1 << EW) - 1) exp_err++;
                            if (!exp_fail) begin exp_felem = e; exp_fadr = a; end
                            exp_fail = 1'b1;
`ifdef BIST_STOP_ON_FAIL_EN
                            stop = 1'b1;
`endif
                        end
                    end else begin
                        mem[a] = wrv[e];
                    end
                end
            end
        end
        exp_len = exp_q.size();
    endtask

    function automatic ctl_t obs();
        ctl_t c;
        bit   op;
        op = bif.read_en | bif.wr_en;
        c.busy = bif.busy; c.done = bif.done; c.rst_adr = bif.rst_adr; c.pr = bif.pr_res_adr;
        c.up_down = bif.up_down; c.rd = bif.read_en; c.wr = bif.wr_en; c.en = bif.enable;
        c.dbit = op ? bif.data_bit : 1'b0;
        c.adr  = op ? bif.adress : '0;
        return c;
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({bif.busy, bif.done, bif.fail, bif.enable, bif.rst_adr, bif.pr_res_adr,
                    bif.up_down, bif.read_en, bif.wr_en, bif.data_bit,
                    bif.fail_elem, bif.fail_adr, bif.err_cnt});
    endfunction

    task automatic run(input int rp, input int rst_at);
        int cyc;
        build_model();
        @(negedge clk); bif.start = 1'b1;
        @(negedge clk); bif.start = 1'b0;
        cyc = 0;
        check_eq("clear_on_start", 32'({bif.done, bif.fail, bif.fail_elem, bif.fail_adr, bif.err_cnt}), 32'd0);
        while (!bif.done && cyc < exp_len + 8) begin
            if (cyc < exp_len) check_eq($sformatf("ctl[%0d]", cyc), 32'(obs()), 32'(exp_q[cyc]));
            if (cyc == rst_at) begin
                rst = 1'b0;
                #1 check_eq("async_reset", all_outs(), 32'd0);
                @(negedge clk); rst = 1'b1;
                return;
            end
            bif.start = (cyc == rp);
            @(negedge clk);
            cyc++;
        end
        bif.start = 1'b0;
        check_eq("run_len", cyc, exp_len);
        check_eq("done_level", 32'({bif.done, bif.busy}), 32'b10);
        check_eq("fail", 32'(bif.fail), 32'(exp_fail));
        check_eq("err_cnt", 32'(bif.err_cnt), exp_err);
        if (exp_fail) begin
            check_eq("fail_elem", 32'(bif.fail_elem), exp_felem);
            check_eq("fail_adr", 32'(bif.fail_adr), exp_fadr);
        end
    endtask

    initial begin
        int d;
        dp_adr = '0;
        bif.start = 1'b0;
        depth = N; flt_en = 1'b0; flt_val = 1'b0; flt_adr = 0; noise_en = 1'b0;
        rst = 1'b0;
        #1 check_eq("reset_outs", all_outs(), 32'd0);
        @(negedge clk); @(negedge clk); rst = 1'b1;

        run(-1, -1);
        flt_en = 1'b1; flt_adr = 5; flt_val = 1'b1;
        run(-1, -1);
        flt_en = 1'b0;
        run(-1, 3 + 3 * N + 2 * 9);              // abort at the M2 read of address 9
        run(-1, -1);
        run($urandom_range(9 * N + 4, 7 * N + 5), -1);
        noise_en = 1'b1; run(-1, -1); noise_en = 1'b0;
        depth = 1; run(-1, -1);
        flt_en = 1'b1; flt_adr = 0; flt_val = 1'b0; run(-1, -1);

        for (int i = 0; i < 10; i++) begin
            d        = $urandom_range(N, 1);
            depth    = d;
            flt_en   = 1'($urandom);
            flt_val  = 1'($urandom);
            flt_adr  = $urandom_range(d - 1, 0);
            noise_en = 1'($urandom);
            run(($urandom_range(1, 0) == 1) ? $urandom_range(10 * d + 5, 0) : -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
